// File: rtl/types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : types_pkg
// Description : Shared types for the load/store unit: data-bus word, access
//               size encoding, LSU state and error codes, plus byte-enable
//               and alignment helpers used at request acceptance.
// Revision    : 1.0 - initial release
// ============================================================================
package types_pkg;

  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0] DATA_BUS;

  typedef enum logic [1:0] {
    Byte = 2'd0,
    Half = 2'd1,
    Word = 2'd2
  } byte_format;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RWAIT = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

  // ERR_ prefix keeps these clear of the TIMEOUT parameter of the LSU.
  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_TIMEOUT  = 2'b10
  } lsu_err_t;

  // Byte enables for an access of the given size at byte offset off.
  // The undefined size encoding is treated as a word access.
  function automatic logic [3:0] be_for(byte_format size, logic [1:0] off);
    logic [3:0] be;
    case (size)
      Byte:    be = 4'b0001 << off;
      Half:    be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic is_misaligned(byte_format size, logic [1:0] off);
    logic mis;
    case (size)
      Byte:    mis = 1'b0;
      Half:    mis = off[0];
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
// Module      : load_extend
// Description : Combinational load-data formatter. Moves the addressed byte
//               or halfword lane of a read word down to bit 0 and sign- or
//               zero-extends it. Word accesses pass the read word through.
// Revision    : 1.0 - initial release
// Ports       : i_rdata - full read word from memory
//               i_off   - byte offset of the access within the word
//               i_size  - access size (Byte / Half / Word)
//               i_sign  - 1 = sign-extend, 0 = zero-extend (Byte/Half only)
//               o_data  - right-justified, extended load result
// ============================================================================
module load_extend
  import types_pkg::*;
(
  input  DATA_BUS    i_rdata,
  input  logic [1:0] i_off,
  input  byte_format i_size,
  input  logic       i_sign,
  output DATA_BUS    o_data
);

  // Only the low 16 bits of the shifted word can ever be selected.
  logic [15:0] w_lane;

  assign w_lane = 16'(i_rdata >> {i_off, 3'b000});

  always_comb begin
    o_data = i_rdata;
    case (i_size)
      Byte:    o_data = {{24{i_sign & w_lane[7]}},  w_lane[7:0]};
      Half:    o_data = {{16{i_sign & w_lane[15]}}, w_lane[15:0]};
      default: o_data = i_rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Data-memory initiator for the pipeline. Accepts one load or
//               store per handshake, issues a word-aligned request with byte
//               enables, formats load data, reports misaligned accesses
//               without touching memory and aborts accesses that time out.
// Revision    : 1.0 - initial release
// Ports       : clk, rst_n               - clock, async active-low reset
//               i_req_* / o_req_ready    - pipeline request handshake
//               o_resp_*                 - one-cycle completion pulse
//               o_stall                  - high while an access is in flight
//               o_mem_* / i_mem_*        - data-memory bus
// ============================================================================
module load_store_unit
  import types_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  // pipeline side
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic       i_req_we,
  input  byte_format i_req_size,
  input  logic       i_req_sign,
  input  DATA_BUS    i_req_addr,
  input  DATA_BUS    i_req_wdata,
  output logic       o_resp_valid,
  output DATA_BUS    o_resp_rdata,
  output logic [1:0] o_resp_err,
  output logic       o_stall,
  // memory side
  output logic       o_mem_req,
  input  logic       i_mem_gnt,
  output logic       o_mem_we,
  output DATA_BUS    o_mem_addr,
  output logic [3:0] o_mem_be,
  output DATA_BUS    o_mem_wdata,
  input  logic       i_mem_rvalid,
  input  DATA_BUS    i_mem_rdata
);

  localparam int               CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  lsu_state_t       r_state;
  lsu_state_t       w_next;
  lsu_err_t         w_err;
  logic             w_accept;
  logic             w_misalign;
  logic             w_expired;
  logic             w_load_done;
  DATA_BUS          w_ext;

  logic [CNT_W-1:0] r_cnt;
  logic             r_we;
  byte_format       r_size;
  logic             r_sign;
  logic [1:0]       r_off;

  logic             r_mem_req;
  logic             r_mem_we;
  DATA_BUS          r_mem_addr;
  logic [3:0]       r_mem_be;
  DATA_BUS          r_mem_wdata;
  logic             r_resp_valid;
  DATA_BUS          r_resp_rdata;
  logic [1:0]       r_resp_err;

  assign w_accept   = i_req_valid && (r_state == IDLE);
  assign w_misalign = is_misaligned(i_req_size, i_req_addr[1:0]);
  assign w_expired  = (r_cnt == CNT_MAX);

  load_extend u_load_extend (
    .i_rdata (i_mem_rdata),
    .i_off   (r_off),
    .i_size  (r_size),
    .i_sign  (r_sign),
    .o_data  (w_ext)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // The awaited bus event is checked before the timeout so a grant or
  // rvalid arriving in the last allowed cycle still completes normally.
  always_comb begin
    w_next      = r_state;
    w_err       = ERR_OK;
    w_load_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_req_valid) begin
          if (w_misalign) begin
            w_next = RESP;
            w_err  = ERR_MISALIGN;
          end else begin
            w_next = REQ;
          end
        end
      end
      REQ: begin
        if (i_mem_gnt) begin
          if (r_we) w_next = RESP;
          else      w_next = RWAIT;
        end else if (w_expired) begin
          w_next = RESP;
          w_err  = ERR_TIMEOUT;
        end
      end
      RWAIT: begin
        if (i_mem_rvalid) begin
          w_next      = RESP;
          w_load_done = 1'b1;
        end else if (w_expired) begin
          w_next = RESP;
          w_err  = ERR_TIMEOUT;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // ------------------------------------------------------------ datapath
  // Outputs are registered from the next state so they line up with the
  // state they describe and drop asynchronously with reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_size       <= Byte;
      r_sign       <= 1'b0;
      r_off        <= 2'b00;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_be     <= 4'b0000;
      r_mem_wdata  <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 2'b00;
    end else begin
      r_mem_req    <= (w_next == REQ);
      r_resp_valid <= (w_next == RESP);
      r_resp_err   <= (w_next == RESP) ? w_err : ERR_OK;
      r_resp_rdata <= w_load_done ? w_ext : '0;

      if (w_accept) begin
        r_cnt       <= '0;
        r_we        <= i_req_we;
        r_size      <= i_req_size;
        r_sign      <= i_req_sign;
        r_off       <= i_req_addr[1:0];
        r_mem_we    <= i_req_we;
        r_mem_addr  <= {i_req_addr[DATA_W-1:2], 2'b00};
        r_mem_be    <= be_for(i_req_size, i_req_addr[1:0]);
        r_mem_wdata <= i_req_wdata << {i_req_addr[1:0], 3'b000};
      end else if ((r_state == REQ || r_state == RWAIT) && !w_expired) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_req_ready  = (r_state == IDLE);
  assign o_stall      = (r_state != IDLE);
  assign o_mem_req    = r_mem_req;
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_be     = r_mem_be;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_err   = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit. Each scenario task
//               drives the pipeline and memory sides cycle by cycle; expected
//               responses go into a scoreboard queue checked by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;
  import types_pkg::*;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  err;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       i_req_valid;
  logic       o_req_ready;
  logic       i_req_we;
  byte_format i_req_size;
  logic       i_req_sign;
  DATA_BUS    i_req_addr;
  DATA_BUS    i_req_wdata;
  logic       o_resp_valid;
  DATA_BUS    o_resp_rdata;
  logic [1:0] o_resp_err;
  logic       o_stall;
  logic       o_mem_req;
  logic       i_mem_gnt;
  logic       o_mem_we;
  DATA_BUS    o_mem_addr;
  logic [3:0] o_mem_be;
  DATA_BUS    o_mem_wdata;
  logic       i_mem_rvalid;
  DATA_BUS    i_mem_rdata;

  int   n_pass;
  int   n_total;
  exp_t sb[$];
  exp_t m_exp;

  load_store_unit #(.TIMEOUT(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_we     (i_req_we),
    .i_req_size   (i_req_size),
    .i_req_sign   (i_req_sign),
    .i_req_addr   (i_req_addr),
    .i_req_wdata  (i_req_wdata),
    .o_resp_valid (o_resp_valid),
    .o_resp_rdata (o_resp_rdata),
    .o_resp_err   (o_resp_err),
    .o_stall      (o_stall),
    .o_mem_req    (o_mem_req),
    .i_mem_gnt    (i_mem_gnt),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_be     (o_mem_be),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every response must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && o_resp_valid) begin
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected: got response rdata=%h err=%b, required no response",
                 o_resp_rdata, o_resp_err);
      end else begin
        m_exp = sb.pop_front();
        if ({o_resp_rdata, o_resp_err} !== m_exp) begin
          $display("FAIL sb_resp: got rdata=%h err=%b, required rdata=%h err=%b",
                   o_resp_rdata, o_resp_err, m_exp.rdata, m_exp.err);
        end else begin
          n_pass++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for the accepting edge; returns 1 ns after it,
  // i.e. in the first cycle after acceptance.
  task automatic issue(input logic we, input byte_format size, input logic sign,
                       input logic [31:0] addr, input logic [31:0] wdata);
    i_req_valid = 1'b1;
    i_req_we    = we;
    i_req_size  = size;
    i_req_sign  = sign;
    i_req_addr  = addr;
    i_req_wdata = wdata;
    step();
    i_req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    i_req_valid  = 1'b0;
    i_req_we     = 1'b0;
    i_req_size   = Byte;
    i_req_sign   = 1'b0;
    i_req_addr   = '0;
    i_req_wdata  = '0;
    i_mem_gnt    = 1'b0;
    i_mem_rvalid = 1'b0;
    i_mem_rdata  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_total++;
    if ({o_req_ready, o_stall, o_mem_req, o_resp_valid, o_mem_we} !== 5'b10000) begin
      $display("FAIL reset_ctrl: got ready/stall/req/rvalid/we=%b, required 10000",
               {o_req_ready, o_stall, o_mem_req, o_resp_valid, o_mem_we});
    end else n_pass++;
    n_total++;
    if ({o_resp_rdata, o_resp_err, o_mem_addr, o_mem_be, o_mem_wdata} !== '0) begin
      $display("FAIL reset_data: got rdata=%h err=%b addr=%h be=%b wdata=%h, required all 0",
               o_resp_rdata, o_resp_err, o_mem_addr, o_mem_be, o_mem_wdata);
    end else n_pass++;
  endtask

  task automatic test_store_byte();
    issue(1'b1, Byte, 1'b0, 32'h0000_1003, 32'h0000_00A5);
    sb.push_back({32'h0, 2'b00});
    i_mem_gnt = 1'b1;
    n_total++;
    if ({o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata} !==
        {1'b1, 1'b1, 32'h0000_1000, 4'b1000, 32'hA500_0000}) begin
      $display("FAIL store_bus: got req=%b we=%b addr=%h be=%b wdata=%h, required 1 1 00001000 1000 a5000000",
               o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata);
    end else n_pass++;
    step();
    i_mem_gnt = 1'b0;
    n_total++;
    if ({o_resp_valid, o_stall, o_mem_req} !== 3'b110) begin
      $display("FAIL store_latency: got resp_valid/stall/req=%b two cycles after accept, required 110",
               {o_resp_valid, o_stall, o_mem_req});
    end else n_pass++;
    step();
    n_total++;
    if ({o_resp_valid, o_stall, o_req_ready} !== 3'b001) begin
      $display("FAIL store_idle: got resp_valid/stall/ready=%b, required 001",
               {o_resp_valid, o_stall, o_req_ready});
    end else n_pass++;
  endtask

  task automatic test_load_half(input logic sign, input logic [31:0] exp_data);
    issue(1'b0, Half, sign, 32'h0000_2002, 32'h0);
    sb.push_back({exp_data, 2'b00});
    i_mem_gnt = 1'b1;
    n_total++;
    if ({o_mem_req, o_mem_we, o_mem_addr, o_mem_be} !== {1'b1, 1'b0, 32'h0000_2000, 4'b1100}) begin
      $display("FAIL load_half_bus: got req=%b we=%b addr=%h be=%b, required 1 0 00002000 1100",
               o_mem_req, o_mem_we, o_mem_addr, o_mem_be);
    end else n_pass++;
    step();
    i_mem_gnt    = 1'b0;
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'h8001_1234;
    step();
    i_mem_rvalid = 1'b0;
    i_mem_rdata  = '0;
    n_total++;
    if (o_resp_valid !== 1'b1) begin
      $display("FAIL load_half_latency: got resp_valid=%b three cycles after accept, required 1",
               o_resp_valid);
    end else n_pass++;
    step();
  endtask

  task automatic test_misaligned();
    issue(1'b0, Word, 1'b0, 32'h0000_0006, 32'h0);
    sb.push_back({32'h0, 2'b01});
    n_total++;
    if ({o_resp_valid, o_stall, o_mem_req, o_resp_err} !== 5'b11001) begin
      $display("FAIL misalign_resp: got resp_valid/stall/req/err=%b, required 11001",
               {o_resp_valid, o_stall, o_mem_req, o_resp_err});
    end else n_pass++;
    step();
    n_total++;
    if ({o_stall, o_mem_req, o_req_ready} !== 3'b001) begin
      $display("FAIL misalign_after: got stall/req/ready=%b, required 001",
               {o_stall, o_mem_req, o_req_ready});
    end else n_pass++;
  endtask

  task automatic test_timeout();
    int cyc;
    issue(1'b0, Byte, 1'b0, 32'h0000_0010, 32'h0);
    sb.push_back({32'h0, 2'b10});
    i_mem_gnt = 1'b1;
    cyc = 0;
    while (cyc < 40) begin
      step();
      i_mem_gnt = 1'b0;
      cyc++;
      if (o_resp_valid) break;
    end
    n_total++;
    if (cyc !== 16) begin
      $display("FAIL timeout_cycles: got response %0d cycles after mem_req rose, required 16", cyc);
    end else n_pass++;
    n_total++;
    if (o_mem_req !== 1'b0) begin
      $display("FAIL timeout_req: got mem_req=%b during timeout response, required 0", o_mem_req);
    end else n_pass++;
    step();
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'hDEAD_BEEF;
    step();
    step();
    i_mem_rvalid = 1'b0;
    i_mem_rdata  = '0;
    step();
    n_total++;
    if ({o_resp_valid, o_stall, o_req_ready} !== 3'b001) begin
      $display("FAIL timeout_late_rvalid: got resp_valid/stall/ready=%b, required 001",
               {o_resp_valid, o_stall, o_req_ready});
    end else n_pass++;
  endtask

  task automatic test_delayed_grant();
    logic held;
    issue(1'b0, Byte, 1'b1, 32'h0000_3000, 32'h0);
    sb.push_back({32'hFFFF_FFFF, 2'b00});
    held = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (o_mem_req !== 1'b1) held = 1'b0;
      step();
    end
    n_total++;
    if (held !== 1'b1 || o_mem_req !== 1'b1) begin
      $display("FAIL delayed_req_held: got held=%b req=%b, required 1 1", held, o_mem_req);
    end else n_pass++;
    i_mem_gnt = 1'b1;
    step();
    i_mem_gnt    = 1'b0;
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'h0000_00FF;
    step();
    i_mem_rvalid = 1'b0;
    i_mem_rdata  = '0;
    n_total++;
    if (o_resp_valid !== 1'b1) begin
      $display("FAIL delayed_resp: got resp_valid=%b, required 1", o_resp_valid);
    end else n_pass++;
    step();
  endtask

  task automatic test_async_reset();
    issue(1'b0, Word, 1'b0, 32'h0000_4000, 32'h0);
    i_mem_gnt = 1'b1;
    step();
    i_mem_gnt = 1'b0;
    n_total++;
    if (o_stall !== 1'b1) begin
      $display("FAIL areset_pre: got stall=%b in read wait, required 1", o_stall);
    end else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({o_req_ready, o_stall, o_mem_req, o_resp_valid} !== 4'b1000) begin
      $display("FAIL areset_async: got ready/stall/req/resp_valid=%b, required 1000",
               {o_req_ready, o_stall, o_mem_req, o_resp_valid});
    end else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    issue(1'b1, Word, 1'b0, 32'h0000_4000, 32'h1234_5678);
    sb.push_back({32'h0, 2'b00});
    i_mem_gnt = 1'b1;
    n_total++;
    if ({o_mem_req, o_mem_be, o_mem_wdata} !== {1'b1, 4'b1111, 32'h1234_5678}) begin
      $display("FAIL areset_next: got req=%b be=%b wdata=%h, required 1 1111 12345678",
               o_mem_req, o_mem_be, o_mem_wdata);
    end else n_pass++;
    step();
    i_mem_gnt = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    issue(1'b1, Half, 1'b0, 32'h0000_5002, 32'h0000_BEEF);
    sb.push_back({32'h0, 2'b00});
    i_mem_gnt = 1'b1;
    n_total++;
    if ({o_mem_be, o_mem_wdata} !== {4'b1100, 32'hBEEF_0000}) begin
      $display("FAIL b2b_store: got be=%b wdata=%h, required 1100 beef0000", o_mem_be, o_mem_wdata);
    end else n_pass++;
    step();
    i_mem_gnt = 1'b0;
    step();
    // first cycle after the response: a new load must be taken immediately
    issue(1'b0, Byte, 1'b0, 32'h0000_5001, 32'h0);
    sb.push_back({32'h0000_0080, 2'b00});
    i_mem_gnt = 1'b1;
    n_total++;
    if ({o_mem_req, o_mem_be} !== 5'b1_0010) begin
      $display("FAIL b2b_load_req: got req=%b be=%b, required 1 0010", o_mem_req, o_mem_be);
    end else n_pass++;
    step();
    i_mem_gnt    = 1'b0;
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'h1234_80AB;
    step();
    i_mem_rvalid = 1'b0;
    step();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_store_byte();
    test_load_half(1'b1, 32'hFFFF_8001);
    test_load_half(1'b0, 32'h0000_8001);
    test_misaligned();
    test_timeout();
    test_delayed_grant();
    test_async_reset();
    test_back_to_back();
    repeat (3) step();
    n_total++;
    if (sb.size() !== 0) begin
      $display("FAIL sb_drained: got %0d outstanding expectations, required 0", sb.size());
    end else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
